// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the E/M/WB hazard scoreboard.
// Stage indices match bit positions of the stall/flush vectors.
package hazard_scoreboard_pkg;

    localparam int STG_F  = 0;
    localparam int STG_D  = 1;
    localparam int STG_E  = 2;
    localparam int STG_M  = 3;
    localparam int STG_WB = 4;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    // Entries carry the widest supported register address; narrower
    // REG_ADDR_W values are zero-extended on the way in.
    localparam int SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               we;
        logic               is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side request fields and hazard-control results between
// control_logic (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int N_SRC      = 3,
    parameter int CNT_W      = 16
);
    logic                        d_valid;
    logic [N_SRC*REG_ADDR_W-1:0] d_rs;
    logic [N_SRC-1:0]            d_rs_used;
    logic [REG_ADDR_W-1:0]       d_rd;
    logic                        d_reg_we;
    logic                        d_is_load;
    logic                        redirect;
    logic                        mem_req;
    logic                        mem_ready;
    logic [4:0]                  stall;
    logic [4:0]                  flush;
    logic [N_SRC*2-1:0]          fwd_sel;
    logic [CNT_W-1:0]            stall_cycles;

    modport master (
        output d_valid, d_rs, d_rs_used, d_rd, d_reg_we, d_is_load,
               redirect, mem_req, mem_ready,
        input  stall, flush, fwd_sel, stall_cycles
    );

    modport slave (
        input  d_valid, d_rs, d_rs_used, d_rd, d_reg_we, d_is_load,
               redirect, mem_req, mem_ready,
        output stall, flush, fwd_sel, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Compares one decode source operand against the three in-flight
// scoreboard entries; x0 and unused operands never hit.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  sb_entry_t             sb_e,
    input  sb_entry_t             sb_m,
    input  sb_entry_t             sb_wb,
    output logic                  hit_e,
    output logic                  hit_e_load,
    output logic                  hit_m,
    output logic                  hit_wb
);
    logic [SB_RD_W-1:0] rs_ext;
    logic               rs_live;
    logic               unused_load_bits;

    assign rs_ext  = SB_RD_W'(rs);
    assign rs_live = used && (rs != '0);

    assign hit_e      = rs_live && sb_e.valid  && sb_e.we  && (sb_e.rd  == rs_ext);
    assign hit_m      = rs_live && sb_m.valid  && sb_m.we  && (sb_m.rd  == rs_ext);
    assign hit_wb     = rs_live && sb_wb.valid && sb_wb.we && (sb_wb.rd == rs_ext);
    assign hit_e_load = hit_e && sb_e.is_load;

    // Only a load still in E has a result that cannot be forwarded yet.
    assign unused_load_bits = sb_m.is_load | sb_wb.is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: tracks writers in E/M/WB and produces per-stage
// stall/flush, registered forwarding selects and a stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int N_SRC      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   hz
);
    sb_entry_t          sb_e_reg, sb_m_reg, sb_wb_reg;
    sb_entry_t          d_entry;
    logic [1:0]         lu_cnt_reg, lu_cnt_next;
    logic [N_SRC*2-1:0] fwd_sel_reg, fwd_sel_next;
    logic [CNT_W-1:0]   stall_cycles_reg;
    logic [N_SRC-1:0]   hit_e, hit_e_load, hit_m, hit_wb;
    logic [4:0]         stall_vec, flush_vec;
    logic               mem_wait, load_hit, data_stall;
    logic               unused_wb_hits;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
                .rs         (hz.d_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
                .used       (hz.d_rs_used[gi]),
                .sb_e       (sb_e_reg),
                .sb_m       (sb_m_reg),
                .sb_wb      (sb_wb_reg),
                .hit_e      (hit_e[gi]),
                .hit_e_load (hit_e_load[gi]),
                .hit_m      (hit_m[gi]),
                .hit_wb     (hit_wb[gi])
            );

            // Youngest producer wins when both E and M hold the register.
            assign fwd_sel_next[gi*2 +: 2] = (FWD_EN == 0) ? FWD_RF :
                                             hit_e[gi]     ? FWD_M  :
                                             hit_m[gi]     ? FWD_WB : FWD_RF;
        end
    endgenerate

    // A WB producer needs no forward: the regfile is write-through.
    assign unused_wb_hits = |hit_wb;

    assign mem_wait = hz.mem_req & ~hz.mem_ready;
    assign load_hit = |hit_e_load;

    always_comb begin
        data_stall = 1'b0;
        if (FWD_EN != 0) begin
            data_stall = load_hit || (lu_cnt_reg != 2'd0);
        end else begin
            data_stall = |(hit_e | hit_m);
        end
    end

    always_comb begin
        stall_vec = '0;
        flush_vec = '0;
        if (!reset) begin
            flush_vec = 5'b11111;
        end else if (mem_wait) begin
            stall_vec         = 5'b11110;
            flush_vec[STG_WB] = 1'b1;
        end else if (hz.redirect) begin
            flush_vec[STG_F] = 1'b1;
            flush_vec[STG_D] = 1'b1;
            flush_vec[STG_E] = 1'b1;
        end else if (data_stall) begin
            stall_vec[STG_F] = 1'b1;
            stall_vec[STG_D] = 1'b1;
            flush_vec[STG_E] = 1'b1;
        end
    end

    // The first detection already stalls one cycle, so load LOAD_LAT-1.
    always_comb begin
        lu_cnt_next = lu_cnt_reg;
        if (mem_wait) begin
            lu_cnt_next = lu_cnt_reg;
        end else if (hz.redirect) begin
            lu_cnt_next = 2'd0;
        end else if (lu_cnt_reg != 2'd0) begin
            lu_cnt_next = lu_cnt_reg - 2'd1;
        end else if ((FWD_EN != 0) && load_hit) begin
            lu_cnt_next = 2'(LOAD_LAT - 1);
        end
    end

    always_comb begin
        d_entry         = SB_EMPTY;
        d_entry.valid   = hz.d_valid & hz.d_reg_we;
        d_entry.rd      = SB_RD_W'(hz.d_rd);
        d_entry.we      = hz.d_reg_we & (hz.d_rd != '0);
        d_entry.is_load = hz.d_is_load;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sb_e_reg         <= SB_EMPTY;
            sb_m_reg         <= SB_EMPTY;
            sb_wb_reg        <= SB_EMPTY;
            lu_cnt_reg       <= 2'd0;
            fwd_sel_reg      <= '0;
            stall_cycles_reg <= '0;
        end else begin
            lu_cnt_reg <= lu_cnt_next;
            if (stall_vec[STG_D] && !(&stall_cycles_reg)) begin
                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
            end
            if (stall_vec[STG_E]) begin
                sb_wb_reg <= SB_EMPTY;
            end else begin
                sb_wb_reg   <= sb_m_reg;
                sb_m_reg    <= sb_e_reg;
                sb_e_reg    <= (stall_vec[STG_D] || flush_vec[STG_D]) ? SB_EMPTY : d_entry;
                fwd_sel_reg <= flush_vec[STG_E] ? '0 : fwd_sel_next;
            end
        end
    end

    assign hz.stall        = stall_vec;
    assign hz.flush        = flush_vec;
    assign hz.fwd_sel      = fwd_sel_reg;
    assign hz.stall_cycles = stall_cycles_reg;

endmodule
